// File: rtl/frame_diff_pkg.sv
// Shared types and defaults for the frame difference scanner.
// Object codes, scan FSM states and default grid size.
package frame_diff_pkg;

  localparam int GRID_W_DEF = 16;
  localparam int GRID_H_DEF = 12;

  typedef enum logic [2:0] {
    OBJ_BG     = 3'd0,
    OBJ_BORDER = 3'd1,
    OBJ_HEAD   = 3'd2,
    OBJ_BODY   = 3'd3,
    OBJ_APPLE  = 3'd4
  } obj_code_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WAIT_CMD,
    DONE
  } scan_state_t;

endpackage

// File: rtl/obj_priority_enc.sv
// Priority encoder: lowest set flag wins, code = index+1, 0 = background.
// The multi-hit output is constant 0 unless MULTI_EN is set.
module obj_priority_enc #(
  parameter int NUM_OBJ  = 4,
  parameter int CODE_W   = $clog2(NUM_OBJ + 1),
  parameter bit MULTI_EN = 1'b0
) (
  input  logic [NUM_OBJ-1:0] flags,
  output logic [CODE_W-1:0]  code,
  output logic               multi
);

  always_comb begin
    code = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (flags[i]) code = CODE_W'(i + 1);
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set
  if (MULTI_EN) begin : g_multi
    assign multi = |(flags & (flags - NUM_OBJ'(1)));
  end else begin : g_nomulti
    assign multi = 1'b0;
  end

endmodule

// File: rtl/frame_diff_scanner.sv
// Raster scanner issuing draw commands for cells changed since last frame.
// Define COLLISION_DETECT_EN to build the sticky multi-flag collision flag.
module frame_diff_scanner
  import frame_diff_pkg::*;
#(
  parameter int GRID_W  = GRID_W_DEF,
  parameter int GRID_H  = GRID_H_DEF,
  parameter int NUM_OBJ = 4,
  localparam int X_W    = $clog2(GRID_W),
  localparam int Y_W    = $clog2(GRID_H),
  localparam int CODE_W = $clog2(NUM_OBJ + 1),
  localparam int CNT_W  = $clog2(GRID_W * GRID_H + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               force_full,
  input  logic [NUM_OBJ-1:0] obj_flags,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic               scan_busy,
  output logic               cmd_valid,
  output logic [X_W-1:0]     cmd_x,
  output logic [Y_W-1:0]     cmd_y,
  output logic [CODE_W-1:0]  cmd_code,
  input  logic               cmd_done,
  output logic               frame_done,
  output logic [CNT_W-1:0]   diff_count,
  output logic               collision
);

  localparam int CELLS = GRID_W * GRID_H;
  localparam int A_W   = $clog2(CELLS);
  localparam logic [X_W-1:0] X_LAST = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(GRID_H - 1);

`ifdef COLLISION_DETECT_EN
  localparam bit MULTI_EN = 1'b1;
`else
  localparam bit MULTI_EN = 1'b0;
`endif

  scan_state_t state, state_d;

  logic [CODE_W-1:0] code;
  logic              multi_hit;
  logic [CODE_W-1:0] fbuf [CELLS];
  logic [A_W-1:0]    addr;
  logic [CNT_W-1:0]  count;
  logic              full_mode;
  logic              full_pending;
  logic              hit;
  logic              last;
  logic              adv;

  obj_priority_enc #(
    .NUM_OBJ  (NUM_OBJ),
    .CODE_W   (CODE_W),
    .MULTI_EN (MULTI_EN)
  ) u_enc (
    .flags (obj_flags),
    .code  (code),
    .multi (multi_hit)
  );

  assign addr = A_W'(y) * A_W'(GRID_W) + A_W'(x);
  assign hit  = full_mode || (code != fbuf[addr]);
  assign last = (x == X_LAST) && (y == Y_LAST);

  always_comb begin
    state_d = state;
    adv     = 1'b0;
    unique case (state)
      IDLE: begin
        if (frame_start) state_d = SCAN;
      end
      SCAN: begin
        if (hit) begin
          state_d = WAIT_CMD;
        end else begin
          adv     = 1'b1;
          state_d = last ? DONE : SCAN;
        end
      end
      WAIT_CMD: begin
        if (cmd_done) begin
          adv     = 1'b1;
          state_d = last ? DONE : SCAN;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x            <= '0;
      y            <= '0;
      scan_busy    <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_x        <= '0;
      cmd_y        <= '0;
      cmd_code     <= '0;
      frame_done   <= 1'b0;
      diff_count   <= '0;
      count        <= '0;
      full_mode    <= 1'b0;
      full_pending <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            x            <= '0;
            y            <= '0;
            scan_busy    <= 1'b1;
            count        <= '0;
            full_mode    <= full_pending | force_full;
            full_pending <= 1'b0;
          end
        end
        SCAN: begin
          if (hit) begin
            cmd_x     <= x;
            cmd_y     <= y;
            cmd_code  <= code;
            cmd_valid <= 1'b1;
            count     <= count + CNT_W'(1);
          end
        end
        WAIT_CMD: begin
          if (cmd_done) cmd_valid <= 1'b0;
        end
        DONE: frame_done <= 1'b0;
        default: ;
      endcase
      if (adv) begin
        if (last) begin
          frame_done <= 1'b1;
          diff_count <= count;
          scan_busy  <= 1'b0;
          x          <= '0;
          y          <= '0;
        end else if (x == X_LAST) begin
          x <= '0;
          y <= y + Y_W'(1);
        end else begin
          x <= x + X_W'(1);
        end
      end
    end
  end

  // Buffer is never cleared; full_pending forces a full redraw after reset
  always_ff @(posedge clk) begin
    if (!rst && state == SCAN && hit) fbuf[addr] <= code;
  end

`ifdef COLLISION_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst)
      collision <= 1'b0;
    else if (state == IDLE && frame_start)
      collision <= 1'b0;
    else if (state == SCAN && multi_hit)
      collision <= 1'b1;
  end
`else
  logic unused_multi;
  assign unused_multi = multi_hit;
  assign collision    = 1'b0;
`endif

endmodule

// File: tb/tb_frame_diff_scanner.sv
// Directed bench for frame_diff_scanner on the default 16x12 grid.
// Scene is a per-cell flag map driven back to obj_flags from x/y.
module tb_frame_diff_scanner;
  import frame_diff_pkg::*;

  localparam int GW = 16;
  localparam int GH = 12;
  localparam int NO = 4;

  logic       tb_clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       force_full = 1'b0;
  logic [3:0] obj_flags;
  logic [3:0] x;
  logic [3:0] y;
  logic       scan_busy;
  logic       cmd_valid;
  logic [3:0] cmd_x;
  logic [3:0] cmd_y;
  logic [2:0] cmd_code;
  logic       cmd_done = 1'b0;
  logic       frame_done;
  logic [7:0] diff_count;
  logic       collision;

  logic [3:0] scene [GH][GW];

  int errors = 0;
  int checks = 0;
  int ncyc;
  int cx[$];
  int cy[$];
  int cc[$];

  frame_diff_scanner #(
    .GRID_W  (GW),
    .GRID_H  (GH),
    .NUM_OBJ (NO)
  ) dut (
    .clk         (tb_clk),
    .rst         (rst),
    .frame_start (frame_start),
    .force_full  (force_full),
    .obj_flags   (obj_flags),
    .x           (x),
    .y           (y),
    .scan_busy   (scan_busy),
    .cmd_valid   (cmd_valid),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_code    (cmd_code),
    .cmd_done    (cmd_done),
    .frame_done  (frame_done),
    .diff_count  (diff_count),
    .collision   (collision)
  );

  always #5 tb_clk = ~tb_clk;

  always_comb begin
    obj_flags = 4'h0;
    if (int'(y) < GH) obj_flags = scene[y][x];
  end

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic start_frame(input bit ff);
    cx.delete();
    cy.delete();
    cc.delete();
    frame_start = 1'b1;
    force_full  = ff;
    tick();
    frame_start = 1'b0;
    force_full  = 1'b0;
    ncyc = 1;
  endtask

  // Acknowledges each command one cycle after it appears
  task automatic finish_frame();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (frame_done) begin
        got = 1'b1;
        break;
      end
      if (cmd_valid && !cmd_done) begin
        cx.push_back(int'(cmd_x));
        cy.push_back(int'(cmd_y));
        cc.push_back(int'(cmd_code));
        cmd_done = 1'b1;
      end else begin
        cmd_done = 1'b0;
      end
      tick();
      ncyc++;
    end
    cmd_done = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL frame_timeout: frame_done=%0b after %0d cycles, required 1", frame_done, ncyc);
    end
  endtask

  task automatic run_frame(input bit ff);
    start_frame(ff);
    finish_frame();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({x, y, scan_busy, cmd_valid, cmd_x, cmd_y, cmd_code,
         frame_done, diff_count, collision} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: x=%0d y=%0d busy=%0b valid=%0b diff=%0d, required all 0",
               x, y, scan_busy, cmd_valid, diff_count);
    end
  endtask

  task automatic test_full_border();
    int bad;
    int ex;
    for (int r = 0; r < GH; r++)
      for (int c = 0; c < GW; c++)
        scene[r][c] = (r == 0 || r == GH - 1 || c == 0 || c == GW - 1) ? 4'b0001 : 4'b0000;
    run_frame(1'b0);
    checks++;
    if (cx.size() != 192) begin
      errors++;
      $display("FAIL border_count: got %0d commands, required 192", cx.size());
    end
    bad = -1;
    for (int i = 0; i < cx.size() && i < 192; i++) begin
      ex = ((i % 16) == 0 || (i % 16) == 15 || (i / 16) == 0 || (i / 16) == 11) ? 1 : 0;
      if (bad < 0 && (cx[i] != i % 16 || cy[i] != i / 16 || cc[i] != ex)) bad = i;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL border_order: cmd %0d is (%0d,%0d,%0d), required (%0d,%0d,%0d)",
               bad, cx[bad], cy[bad], cc[bad], bad % 16, bad / 16,
               ((bad % 16) == 0 || (bad % 16) == 15 || (bad / 16) == 0 || (bad / 16) == 11) ? 1 : 0);
    end
    checks++;
    if (diff_count !== 8'd192 || scan_busy !== 1'b0) begin
      errors++;
      $display("FAIL border_diff: diff=%0d busy=%0b, required 192 and 0", diff_count, scan_busy);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: frame_done=%0b one cycle later, required 0", frame_done);
    end
  endtask

  task automatic test_unchanged();
    run_frame(1'b0);
    checks++;
    if (cx.size() != 0) begin
      errors++;
      $display("FAIL same_count: got %0d commands, required 0", cx.size());
    end
    checks++;
    if (ncyc != 193) begin
      errors++;
      $display("FAIL same_latency: frame_done %0d cycles after start, required 193", ncyc);
    end
    checks++;
    if (diff_count !== 8'd0) begin
      errors++;
      $display("FAIL same_diff: diff=%0d, required 0", diff_count);
    end
    tick();
  endtask

  task automatic test_head_move();
    scene[4][4] = 4'b0010;
    run_frame(1'b0);
    checks++;
    if (cx.size() != 1 || cx[0] != 4 || cy[0] != 4 || cc[0] != int'(OBJ_HEAD)) begin
      errors++;
      $display("FAIL head_place: %0d cmds first=(%0d,%0d,%0d), required 1 cmd (4,4,2)",
               cx.size(), cx.size() ? cx[0] : -1, cx.size() ? cy[0] : -1, cx.size() ? cc[0] : -1);
    end
    tick();
    scene[4][4] = 4'b0000;
    scene[4][5] = 4'b0010;
    run_frame(1'b0);
    checks++;
    if (cx.size() != 2) begin
      errors++;
      $display("FAIL move_count: got %0d commands, required 2", cx.size());
    end else begin
      checks++;
      if (cx[0] != 4 || cy[0] != 4 || cc[0] != 0 || cx[1] != 5 || cy[1] != 4 || cc[1] != 2) begin
        errors++;
        $display("FAIL move_cmds: got (%0d,%0d,%0d),(%0d,%0d,%0d), required (4,4,0),(5,4,2)",
                 cx[0], cy[0], cc[0], cx[1], cy[1], cc[1]);
      end
    end
    checks++;
    if (diff_count !== 8'd2) begin
      errors++;
      $display("FAIL move_diff: diff=%0d, required 2", diff_count);
    end
    tick();
  endtask

  task automatic test_stall();
    int unstable;
    bit seen;
    scene[4][7] = 4'b1000;
    start_frame(1'b0);
    seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (cmd_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!seen || cmd_x !== 4'd7 || cmd_y !== 4'd4 || cmd_code !== 3'(OBJ_APPLE)) begin
      errors++;
      $display("FAIL stall_cmd: valid=%0b cmd=(%0d,%0d,%0d), required 1 (7,4,4)",
               cmd_valid, cmd_x, cmd_y, cmd_code);
    end
    unstable = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (cmd_valid !== 1'b1 || x !== 4'd7 || y !== 4'd4 || cmd_x !== 4'd7 ||
          cmd_y !== 4'd4 || cmd_code !== 3'd4)
        unstable++;
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL stall_hold: %0d of 20 cycles unstable, required 0", unstable);
    end
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0 || x !== 4'd8 || y !== 4'd4) begin
      errors++;
      $display("FAIL stall_resume: valid=%0b at (%0d,%0d), required 0 at (8,4)", cmd_valid, x, y);
    end
    finish_frame();
    checks++;
    if (diff_count !== 8'd1) begin
      errors++;
      $display("FAIL stall_diff: diff=%0d, required 1", diff_count);
    end
    tick();
  endtask

  task automatic test_force_full();
    run_frame(1'b1);
    checks++;
    if (cx.size() != 192 || diff_count !== 8'd192) begin
      errors++;
      $display("FAIL force_count: %0d cmds diff=%0d, required 192", cx.size(), diff_count);
    end
    tick();
    run_frame(1'b0);
    checks++;
    if (cx.size() != 0 || diff_count !== 8'd0) begin
      errors++;
      $display("FAIL after_force: %0d cmds diff=%0d, required 0", cx.size(), diff_count);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen;
    start_frame(1'b0);
    seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (x == 4'd2 && y == 4'd3) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!seen || scan_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reach: busy=%0b at (%0d,%0d), required 1 at (2,3)", scan_busy, x, y);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({x, y, scan_busy, cmd_valid, cmd_x, cmd_y, cmd_code,
         frame_done, diff_count, collision} !== '0) begin
      errors++;
      $display("FAIL mid_reset: x=%0d y=%0d busy=%0b valid=%0b diff=%0d, required all 0",
               x, y, scan_busy, cmd_valid, diff_count);
    end
    run_frame(1'b0);
    checks++;
    if (cx.size() != 192 || diff_count !== 8'd192) begin
      errors++;
      $display("FAIL mid_redraw: %0d cmds diff=%0d, required 192", cx.size(), diff_count);
    end
    tick();
  endtask

  task automatic test_collision();
    scene[4][6] = 4'b0110;
    run_frame(1'b0);
    checks++;
    if (cx.size() != 1 || cx[0] != 6 || cy[0] != 4 || cc[0] != int'(OBJ_HEAD)) begin
      errors++;
      $display("FAIL multi_code: %0d cmds first=(%0d,%0d,%0d), required 1 cmd (6,4,2)",
               cx.size(), cx.size() ? cx[0] : -1, cx.size() ? cy[0] : -1, cx.size() ? cc[0] : -1);
    end
`ifdef COLLISION_DETECT_EN
    checks++;
    if (collision !== 1'b1) begin
      errors++;
      $display("FAIL collision_set: collision=%0b, required 1", collision);
    end
    scene[4][6] = 4'b0100;
    tick();
    start_frame(1'b0);
    checks++;
    if (collision !== 1'b0) begin
      errors++;
      $display("FAIL collision_clear: collision=%0b, required 0", collision);
    end
    finish_frame();
`else
    checks++;
    if (collision !== 1'b0) begin
      errors++;
      $display("FAIL collision_tied: collision=%0b, required 0", collision);
    end
`endif
    tick();
  endtask

  initial begin
    for (int r = 0; r < GH; r++)
      for (int c = 0; c < GW; c++)
        scene[r][c] = 4'h0;
    test_reset();
    test_full_border();
    test_unchanged();
    test_head_move();
    test_stall();
    test_force_full();
    test_reset_mid();
    test_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
